dmem_bus_ctrl: RTL and testbench
================================

# dmem_bus_ctrl

Data-memory bus controller sitting directly downstream of the MEM stage. It turns MEM's combinational memory request (ce/we/sel/addr/data) into a registered request/acknowledge transaction on the data-RAM bus. It holds the pipeline with a stall request until the bus completes, then presents read data back to MEM's `mem_data_i` with the addressed byte aligned to bits [31:24]. A timeout terminates hung transactions.

## Interface
Parameters:
- `TIMEOUT`, 255: maximum BUSY cycles without `bus_ack_i` before abort; range 1..255.

Ports:
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `mem_ce_i` in 1: access request from MEM (`mem_ce_o`).
- `mem_we_i` in 1: 1 = write, 0 = read.
- `mem_sel_i` in 1: 1 = full word, 0 = single byte (writes only).
- `mem_addr_i` in 32: byte address.
- `mem_wdata_i` in 32: write data; byte writes arrive already replicated to all four lanes.
- `mem_rdata_o` out 32: read data to MEM; the addressed byte is in [31:24].
- `stall_req_o` out 1: pipeline hold request, combinational.
- `bus_req_o` out 1: bus request, registered.
- `bus_we_o` out 1: bus write strobe.
- `bus_be_o` out 4: byte enables; bit 3 = lane [31:24].
- `bus_addr_o` out 32: word address, `{mem_addr_i[31:2],2'b00}`.
- `bus_wdata_o` out 32: write data.
- `bus_rdata_i` in 32: bus read word, big-endian; byte offset 0 is in [31:24].
- `bus_ack_i` in 1: transaction complete; sampled only in BUSY.
- `bus_err_o` out 1: one-cycle pulse on timeout abort.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If `mem_ce_i`=1, latch we, addr, wdata, byte enables and byte offset `off=mem_addr_i[1:0]`.
  - Set `bus_req_o`=1, clear the timeout counter, go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - Hold `bus_req_o` and all `bus_*` outputs stable.
  - On `bus_ack_i`=1: capture the read data, drop `bus_req_o`, go to DONE.
  - Otherwise increment the counter; when it reaches `TIMEOUT`, drop `bus_req_o`, set captured data to 0, pulse `bus_err_o`, go to DONE.
- DONE:
  - Present the captured data on `mem_rdata_o`; `stall_req_o`=0 so the pipeline advances at this edge.
  - Always return to IDLE; never launch a new request from DONE.
- Byte enables:
  - `mem_sel_i`=1 gives 4'b1111.
  - `mem_sel_i`=0 gives a one-hot enable by offset: 0→1000, 1→0100, 2→0010, 3→0001.
  - Reads always use 4'b1111.
- Read alignment: captured data = `bus_rdata_i` rotated left by 8·off bits.
  - off=0: unchanged.
  - off=1: `{r[23:0],r[31:24]}`, and so on.
  - This puts the byte at off in [31:24] and the halfword at off=2 in [31:16].
- Writes: `bus_wdata_o` = latched `mem_wdata_i` unchanged. `mem_rdata_o` in DONE after a write is 0.
- `stall_req_o` = (state==IDLE && `mem_ce_i`) || state==BUSY.
- `mem_rdata_o` = 0 in IDLE and BUSY.
- Inputs are ignored in BUSY and DONE; MEM inputs are held stable by the stall.
- `bus_ack_i` outside BUSY is ignored.
- Ack arriving in the same cycle the counter reaches `TIMEOUT`: ack wins, and no `bus_err_o` pulse.

## Timing
- Reset: state IDLE, counter 0. Every registered output is 0 on the first edge with `rst`=1: `bus_req_o`, `bus_we_o`, `bus_be_o`, `bus_addr_o`, `bus_wdata_o`, `bus_err_o`, captured data.
- Reset mid-transaction (BUSY or DONE): return to IDLE and drop `bus_req_o` at that edge; no err pulse.
- Reset has priority over `bus_ack_i`.
- Access latency:
  - `bus_req_o` rises at the edge leaving IDLE.
  - An ack in the first BUSY cycle gives DONE one cycle later.
  - Minimum occupancy is 3 cycles (IDLE, BUSY, DONE), with stall high for 2.
  - Each wait cycle adds one.
- Back-to-back requests: the next instruction's request is seen in the IDLE cycle after DONE, so one bus-idle cycle falls between transactions.
- Timeout: `bus_err_o` is high for exactly the DONE cycle; abort occurs after `TIMEOUT` BUSY cycles.

## Test plan
- **Reset:** hold `rst` 2 cycles with `mem_ce_i`=1 → all outputs 0, `bus_req_o` never rises; after release, the request launches on the next edge.
- **Word read, zero wait:** read of addr 0x104 with `bus_ack_i` returning 0xDEADBEEF in the first BUSY cycle → `bus_addr_o`=0x104, `bus_be_o`=1111, stall high 2 cycles, `mem_rdata_o`=0xDEADBEEF in DONE.
- **Byte read, offset 3, 3 wait cycles:** read of addr 0x107 with `bus_rdata_i`=0x11223344 → `bus_addr_o`=0x104, stall high 5 cycles, `mem_rdata_o`=0x44112233.
- **Byte write, offset 1:** write of addr 0x201, sel=0, wdata 0xABABABAB → `bus_be_o`=0100, `bus_we_o`=1, `bus_addr_o`=0x200, `bus_wdata_o`=0xABABABAB.
- **Timeout:** `TIMEOUT`=4, no ack → `bus_req_o` high exactly 4 cycles, then `bus_err_o`=1 for one cycle, `mem_rdata_o`=0, pipeline released.
- **Ack/timeout collision and mid-op reset:** ack on the 4th BUSY cycle with `TIMEOUT`=4 → no err and data captured; then `rst` pulsed in BUSY → IDLE and `bus_req_o`=0 next cycle.

Source files
------------

// File: rtl/dmem_bus_if.sv
// Data-RAM bus bundle between the MEM-stage bus controller (master) and the RAM (slave).
// Signal names keep the controller's point of view: _o driven by the master, _i by the slave.
interface dmem_bus_if;
   logic        bus_req_o;
   logic        bus_we_o;
   logic [3:0]  bus_be_o;
   logic [31:0] bus_addr_o;
   logic [31:0] bus_wdata_o;
   logic [31:0] bus_rdata_i;
   logic        bus_ack_i;
   logic        bus_err_o;

   modport master (
      output bus_req_o,
      output bus_we_o,
      output bus_be_o,
      output bus_addr_o,
      output bus_wdata_o,
      output bus_err_o,
      input  bus_rdata_i,
      input  bus_ack_i
   );

   modport slave (
      input  bus_req_o,
      input  bus_we_o,
      input  bus_be_o,
      input  bus_addr_o,
      input  bus_wdata_o,
      input  bus_err_o,
      output bus_rdata_i,
      output bus_ack_i
   );
endinterface

// File: rtl/dmem_bus_ctrl.sv
// Turns MEM's combinational load/store request into a registered req/ack bus transaction,
// stalling the pipeline until completion and returning read data byte-aligned to [31:24].
module dmem_bus_ctrl #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_ce_i,
   input  logic        mem_we_i,
   input  logic        mem_sel_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] mem_wdata_i,
   output logic [31:0] mem_rdata_o,
   output logic        stall_req_o,
   dmem_bus_if.master  bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_e;

   // Abort fires in the BUSY cycle whose pre-increment count is TIMEOUT-1.
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 32'd1);

   state_e      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [1:0]  off_q, off_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic        timeout_hit_s;
   logic        stall_s;

   function automatic logic [3:0] byte_en(input logic we, input logic sel, input logic [1:0] off);
      logic [3:0] be;
      if (we && !sel) begin
         case (off)
            2'd0:    be = 4'b1000;
            2'd1:    be = 4'b0100;
            2'd2:    be = 4'b0010;
            2'd3:    be = 4'b0001;
            default: be = 4'b0000;
         endcase
      end else begin
         be = 4'b1111;
      end
      return be;
   endfunction

   // Big-endian bus word: rotating left by whole bytes brings the addressed byte to [31:24].
   function automatic logic [31:0] align_rdata(input logic [31:0] r, input logic [1:0] off);
      logic [31:0] a;
      case (off)
         2'd0:    a = r;
         2'd1:    a = {r[23:0], r[31:24]};
         2'd2:    a = {r[15:0], r[31:16]};
         2'd3:    a = {r[7:0],  r[31:8]};
         default: a = 32'h0000_0000;
      endcase
      return a;
   endfunction

   assign timeout_hit_s = (cnt_q == TO_LAST);

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (mem_ce_i) begin
               state_d = S_BUSY;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_BUSY: begin
            if (bus.bus_ack_i || timeout_hit_s) begin
               state_d = S_DONE;
            end else begin
               state_d = S_BUSY;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM output and datapath next-value logic
   always_comb begin
      cnt_d   = cnt_q;
      req_d   = req_q;
      we_d    = we_q;
      be_d    = be_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      off_d   = off_q;
      rdata_d = 32'h0000_0000;
      err_d   = 1'b0;
      stall_s = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (mem_ce_i) begin
               stall_s = 1'b1;
               req_d   = 1'b1;
               cnt_d   = 8'd0;
               we_d    = mem_we_i;
               be_d    = byte_en(mem_we_i, mem_sel_i, mem_addr_i[1:0]);
               addr_d  = {mem_addr_i[31:2], 2'b00};
               wdata_d = mem_wdata_i;
               off_d   = mem_addr_i[1:0];
            end else begin
               stall_s = 1'b0;
               req_d   = 1'b0;
            end
         end
         S_BUSY: begin
            stall_s = 1'b1;
            // Ack takes priority over a simultaneous timeout.
            if (bus.bus_ack_i) begin
               req_d = 1'b0;
               if (we_q) begin
                  rdata_d = 32'h0000_0000;
               end else begin
                  rdata_d = align_rdata(bus.bus_rdata_i, off_q);
               end
            end else if (timeout_hit_s) begin
               req_d = 1'b0;
               err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_DONE: begin
            stall_s = 1'b0;
            req_d   = 1'b0;
         end
         default: begin
            stall_s = 1'b0;
            req_d   = 1'b0;
         end
      endcase
   end

   // Datapath and registered bus outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= 8'd0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         be_q    <= 4'b0000;
         addr_q  <= 32'h0000_0000;
         wdata_q <= 32'h0000_0000;
         off_q   <= 2'd0;
         rdata_q <= 32'h0000_0000;
         err_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         we_q    <= we_d;
         be_q    <= be_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         off_q   <= off_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign stall_req_o     = stall_s;
   assign mem_rdata_o     = rdata_q;
   assign bus.bus_req_o   = req_q;
   assign bus.bus_we_o    = we_q;
   assign bus.bus_be_o    = be_q;
   assign bus.bus_addr_o  = addr_q;
   assign bus.bus_wdata_o = wdata_q;
   assign bus.bus_err_o   = err_q;

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Randomized bench for dmem_bus_ctrl: a transaction-level model expands each access into
// its expected per-cycle output trace, which a single compare process checks every cycle.
module tb_dmem_bus_ctrl;
   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_ce_i, mem_we_i, mem_sel_i;
   logic [31:0] mem_addr_i, mem_wdata_i;
   logic [31:0] mem_rdata_o;
   logic        stall_req_o;

   dmem_bus_if bif ();

   dmem_bus_ctrl #(.TIMEOUT(TO)) dut (
      .clk         (clk),
      .rst         (rst),
      .mem_ce_i    (mem_ce_i),
      .mem_we_i    (mem_we_i),
      .mem_sel_i   (mem_sel_i),
      .mem_addr_i  (mem_addr_i),
      .mem_wdata_i (mem_wdata_i),
      .mem_rdata_o (mem_rdata_o),
      .stall_req_o (stall_req_o),
      .bus         (bif)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        chk_stall;
      logic        stall;
      logic        req;
      logic        err;
      logic [31:0] rdata;
      logic        chk_bus;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic [31:0] model_rot(input logic [31:0] r, input logic [1:0] off);
      logic [63:0] t;
      t = {r, r} << (8 * int'(off));
      return t[63:32];
   endfunction

   function automatic logic [3:0] model_be(input logic we, input logic sel, input logic [1:0] off);
      logic [3:0] one_hot;
      one_hot = 4'b1000 >> off;
      return (we && !sel) ? one_hot : 4'hF;
   endfunction

   function automatic exp_t quiet(input logic chk_stall);
      exp_t e;
      e = '0;
      e.chk_stall = chk_stall;
      return e;
   endfunction

   // Per-cycle compare against the model trace
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.chk_stall) chk("stall", {31'd0, stall_req_o}, {31'd0, e.stall});
            chk("bus_req", {31'd0, bif.bus_req_o}, {31'd0, e.req});
            chk("bus_err", {31'd0, bif.bus_err_o}, {31'd0, e.err});
            chk("mem_rdata", mem_rdata_o, e.rdata);
            if (e.chk_bus) begin
               chk("bus_we", {31'd0, bif.bus_we_o}, {31'd0, e.we});
               chk("bus_be", {28'd0, bif.bus_be_o}, {28'd0, e.be});
               chk("bus_addr", bif.bus_addr_o, e.addr);
               chk("bus_wdata", bif.bus_wdata_o, e.wdata);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         rst = 1'b0;
         mem_ce_i = 1'b0;
         mem_addr_i = $urandom;
         bif.bus_ack_i = 1'($urandom_range(0, 1));
         bif.bus_rdata_i = $urandom;
         exp_q.push_back(quiet(1'b1));
      end
   endtask

   // One access: ack_at = BUSY cycle carrying the ack (outside 1..TO means none);
   // rst_at = BUSY cycle index (or nb+1 for DONE) in which rst is pulsed, 0 for none.
   task automatic do_txn(input logic we, input logic sel, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int ack_at, input int rst_at,
                         input logic lit_en, input logic [31:0] lit_rdata, input logic [3:0] lit_be);
      exp_t e;
      logic timed_out;
      int   nb;
      logic [31:0] exp_rdata;
      timed_out = !(ack_at >= 1 && ack_at <= TO);
      nb = timed_out ? TO : ack_at;
      exp_rdata = (timed_out || we) ? 32'h0 : model_rot(rdata, addr[1:0]);

      tick();
      rst = 1'b0;
      mem_ce_i = 1'b1; mem_we_i = we; mem_sel_i = sel;
      mem_addr_i = addr; mem_wdata_i = wdata;
      bif.bus_ack_i = 1'($urandom_range(0, 1));
      bif.bus_rdata_i = $urandom;
      e = quiet(1'b1);
      e.stall = 1'b1;
      exp_q.push_back(e);

      for (int k = 1; k <= nb; k++) begin
         tick();
         bif.bus_ack_i = (k == ack_at);
         bif.bus_rdata_i = (k == ack_at) ? rdata : $urandom;
         rst = (k == rst_at);
         e = quiet(1'b1);
         e.stall = 1'b1; e.req = 1'b1; e.chk_bus = 1'b1;
         e.we = we; e.be = model_be(we, sel, addr[1:0]);
         e.addr = {addr[31:2], 2'b00}; e.wdata = wdata;
         exp_q.push_back(e);
         if (lit_en && k == 1) begin
            #1;
            chk("lit_be", {28'd0, bif.bus_be_o}, {28'd0, lit_be});
         end
         if (k == rst_at) begin
            idle(1);
            return;
         end
      end

      tick();
      mem_ce_i = 1'($urandom_range(0, 1));
      mem_we_i = 1'($urandom_range(0, 1));
      mem_addr_i = $urandom;
      bif.bus_ack_i = 1'($urandom_range(0, 1));
      bif.bus_rdata_i = $urandom;
      rst = (rst_at == nb + 1);
      e = quiet(1'b1);
      e.err = timed_out;
      e.rdata = exp_rdata;
      exp_q.push_back(e);
      if (lit_en) begin
         #1;
         chk("lit_rdata", mem_rdata_o, lit_rdata);
      end
   endtask

   initial begin
      logic        we, sel;
      logic [31:0] addr;
      int          rst_at;
      rst = 1'b1;
      mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 1'b1;
      mem_addr_i = 32'h0000_0104; mem_wdata_i = 32'h0;
      bif.bus_ack_i = 1'b0; bif.bus_rdata_i = 32'h0;

      // Two reset cycles with a pending request: nothing may launch.
      for (int i = 0; i < 2; i++) begin
         tick();
         rst = 1'b1;
         mem_ce_i = 1'b1;
         exp_q.push_back(quiet(1'b0));
      end

      do_txn(1'b0, 1'b1, 32'h0000_0104, 32'h0, 32'hDEADBEEF, 1, 0, 1'b1, 32'hDEADBEEF, 4'b1111);
      do_txn(1'b0, 1'b0, 32'h0000_0107, 32'h0, 32'h11223344, 4, 0, 1'b1, 32'h44112233, 4'b1111);
      idle(1);
      do_txn(1'b1, 1'b0, 32'h0000_0201, 32'hABABABAB, 32'h55555555, 2, 0, 1'b1, 32'h0, 4'b0100);
      do_txn(1'b0, 1'b1, 32'h0000_0300, 32'h0, 32'h12345678, 0, 0, 1'b1, 32'h0, 4'b1111);
      do_txn(1'b0, 1'b0, 32'h0000_0002, 32'h0, 32'hCAFEF00D, 4, 0, 1'b1, 32'hF00DCAFE, 4'b1111);
      do_txn(1'b0, 1'b1, 32'h0000_0400, 32'h0, 32'h0BADF00D, 3, 2, 1'b0, 32'h0, 4'b0);
      idle(2);

      for (int t = 0; t < 200; t++) begin
         we   = 1'($urandom_range(0, 1));
         sel  = 1'($urandom_range(0, 1));
         addr = $urandom;
         rst_at = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 5) : 0;
         do_txn(we, sel, addr, $urandom, $urandom, $urandom_range(0, 6), rst_at,
                1'b0, 32'h0, 4'b0);
         idle($urandom_range(0, 2));
      end

      idle(2);
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
